// File: rtl/jtframe_rom_pkg.sv
// Shared definitions for the ROM read scheduler: default geometry and the
// SDRAM-side FSM state encoding.
package jtframe_rom_pkg;

    localparam int DEF_SLOTS = 4;
    localparam int DEF_AW    = 22;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/jtframe_rom_slot.sv
// One-word cache entry for a single ROM requester: tag, data, valid bit and
// the hit compare against the requester's current address.
module jtframe_rom_slot import jtframe_rom_pkg::*; #(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic          ok,
    output logic          miss,
    output logic [31:0]   dout
);

    logic [AW-1:0] tag;
    logic [31:0]   data;
    logic          valid;
    logic          hit;

    // clr wins over a fill so nothing loaded during a ROM download survives
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (we) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
        end
    end

    assign hit  = valid && (tag == addr);
    assign ok   = cs && hit && !clr;
    assign miss = cs && !hit;
    assign dout = data;

endmodule

// File: rtl/jtframe_rom_sched.sv
// Round of fixed-priority ROM fetches: each slot owns a one-word cache and
// misses are served one at a time through a single SDRAM request port.
module jtframe_rom_sched import jtframe_rom_pkg::*; #(
    parameter int SLOTS = DEF_SLOTS,
    parameter int AW    = DEF_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    input  logic                downloading,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t        state;
    logic [IW-1:0] sel;
    logic [IW-1:0] pick;
    logic [SLOTS-1:0] miss;
    logic [SLOTS-1:0] fill;
    logic [AW-1:0]    addr_arr [SLOTS];

    // The fill tag is the latched request address, not the slot's live address
    for (genvar n = 0; n < SLOTS; n++) begin : g_slot
        assign addr_arr[n] = slot_addr[n*AW +: AW];
        assign fill[n]     = (state == ST_WAIT_DATA) && data_rdy && (sel == IW'(n));

        jtframe_rom_slot #(.AW(AW)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (downloading),
            .we      (fill[n]),
            .wr_tag  (sdram_addr),
            .wr_data (data_read),
            .cs      (slot_cs[n]),
            .addr    (addr_arr[n]),
            .ok      (slot_ok[n]),
            .miss    (miss[n]),
            .dout    (slot_dout[n*32 +: 32])
        );
    end

    always_comb begin
        pick = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (miss[i]) pick = IW'(i);
        end
    end

    assign refresh_en = (state == ST_IDLE) && !(|miss) && !downloading;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else if (downloading) begin
            state     <= ST_IDLE;
            sdram_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|miss) begin
                        sel        <= pick;
                        sdram_addr <= addr_arr[pick];
                        sdram_req  <= 1'b1;
                        state      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_rdy) state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    sdram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_sched.sv
// Bench for jtframe_rom_sched: an SDRAM responder plus a per-slot cache model
// drives directed scenarios and a randomized soak; requests go through a scoreboard.
module tb_jtframe_rom_sched;

    localparam int SLOTS = 4;
    localparam int AW    = 22;

    // clock / reset / DUT
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                downloading = 1'b0;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [31:0]         data_read = '0;
    logic                refresh_en;

    always #5 clk = ~clk;

    jtframe_rom_sched #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .downloading (downloading),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    // reference model: one cached word per slot
    logic          m_valid [SLOTS];
    logic [AW-1:0] m_tag   [SLOTS];
    logic [31:0]   m_data  [SLOTS];

    // next-cycle stimulus
    logic [SLOTS-1:0] cs_n = '0;
    logic [AW-1:0]    addr_n [SLOTS];
    logic             dl_n = 1'b0;
    logic             rst_n = 1'b1;
    logic             spur_rdy = 1'b0;

    // SDRAM responder: 0 = no transaction, 1 = request outstanding, 2 = awaiting data
    int            phase = 0;
    int            cnt = 0;
    int            cur_slot = 0;
    logic [AW-1:0] cur_addr = '0;
    bit            rand_mode = 1'b0;
    bit            chk_on = 1'b0;
    int            ack_lat = 1;
    int            dat_lat = 1;
    logic [31:0]   fixed_data = 32'h0;

    // scoreboard
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] req_log [$];
    int            req_count = 0;
    logic          req_prev = 1'b0;
    int            n_checks = 0;
    int            n_errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_miss();
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_cs[i] && !(m_valid[i] && m_tag[i] == slot_addr[i*AW +: AW])) return i;
        end
        return -1;
    endfunction

    function automatic void model_clear(input bit full);
        for (int i = 0; i < SLOTS; i++) begin
            m_valid[i] = 1'b0;
            if (full) begin
                m_tag[i]  = '0;
                m_data[i] = '0;
            end
        end
    endfunction

    // one clock: check outputs, apply next inputs, advance the responder
    task automatic step();
        int lm;
        @(negedge clk);
        if (chk_on) begin
            for (int n = 0; n < SLOTS; n++) begin
                logic exp_ok;
                exp_ok = slot_cs[n] && m_valid[n] && (m_tag[n] == slot_addr[n*AW +: AW]) && !downloading;
                check($sformatf("slot_ok[%0d]", n), slot_ok[n], exp_ok);
                if (exp_ok) check($sformatf("slot_dout[%0d]", n), slot_dout[n*32 +: 32], m_data[n]);
            end
            check("sdram_req", sdram_req, phase == 1);
            if (phase == 1) check("sdram_addr", sdram_addr, cur_addr);
            check("refresh_en", refresh_en, phase == 0 && !downloading && lowest_miss() < 0);
        end
        rst         = rst_n;
        downloading = dl_n;
        slot_cs     = cs_n;
        for (int n = 0; n < SLOTS; n++) slot_addr[n*AW +: AW] = addr_n[n];
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = $urandom;
        if (rst_n) begin
            model_clear(1'b1);
            phase = 0;
        end else if (dl_n) begin
            model_clear(1'b0);
            phase = 0;
        end else begin
            lm = lowest_miss();
            if (phase == 0 && lm >= 0) begin
                cur_slot = lm;
                cur_addr = addr_n[lm];
                exp_q.push_back(cur_addr);
                phase = 1;
                cnt = rand_mode ? int'($urandom_range(1, 3)) : ack_lat;
            end else if (phase == 1) begin
                if (cnt == 0) begin
                    sdram_ack = 1'b1;
                    phase = 2;
                    cnt = rand_mode ? int'($urandom_range(0, 3)) : dat_lat;
                end else begin
                    cnt--;
                    if (rand_mode && $urandom_range(0, 7) == 0) data_rdy = 1'b1;
                end
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    data_rdy = 1'b1;
                    if (!rand_mode) data_read = fixed_data;
                    m_valid[cur_slot] = 1'b1;
                    m_tag[cur_slot]   = cur_addr;
                    m_data[cur_slot]  = data_read;
                    phase = 0;
                end else begin
                    cnt--;
                    if (rand_mode && $urandom_range(0, 7) == 0) sdram_ack = 1'b1;
                end
            end else begin
                if (spur_rdy || (rand_mode && $urandom_range(0, 7) == 0)) data_rdy = 1'b1;
                if (rand_mode && $urandom_range(0, 7) == 0) sdram_ack = 1'b1;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 20 && phase != p; i++) step();
        check("wait_phase", phase, p);
    endtask

    // monitor: every new request is popped against the expected queue
    always @(negedge clk) begin
        if (sdram_req === 1'b1 && req_prev !== 1'b1) begin
            req_count++;
            req_log.push_back(sdram_addr);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_req: got addr %h expected none", sdram_addr);
            end else begin
                check("req_addr", sdram_addr, exp_q.pop_front());
            end
        end
        req_prev = sdram_req;
    end

    initial begin
        int start;
        int cnt0;
        for (int n = 0; n < SLOTS; n++) addr_n[n] = '0;
        model_clear(1'b1);

        // reset
        step();
        chk_on = 1'b1;
        steps(2);
        rst_n = 1'b0;
        step();
        #1;
        check("rst_sdram_addr", sdram_addr, 0);
        check("rst_slot_ok", slot_ok, 0);
        check("rst_refresh_en", refresh_en, 1);

        // single miss on slot 1
        ack_lat = 2;
        dat_lat = 3;
        fixed_data = 32'hDEADBEEF;
        start = req_log.size();
        addr_n[1] = 22'h00123;
        cs_n = 4'b0010;
        steps(12);
        #1;
        check("single_req_count", req_log.size() - start, 1);
        check("single_slot_ok", slot_ok[1], 1);
        check("single_dout", slot_dout[32 +: 32], 32'hDEADBEEF);

        // hit on slot 2 after it is cached
        fixed_data = 32'h5555AAAA;
        addr_n[2] = 22'h00055;
        cs_n = 4'b0100;
        steps(12);
        cnt0 = req_count;
        steps(6);
        #1;
        check("hit_no_req", req_count - cnt0, 0);
        check("hit_slot_ok", slot_ok[2], 1);
        check("hit_dout", slot_dout[64 +: 32], 32'h5555AAAA);

        // slots 0 and 3 miss together
        fixed_data = 32'h01234567;
        start = req_log.size();
        addr_n[0] = 22'h00300;
        addr_n[3] = 22'h00333;
        cs_n = 4'b1001;
        steps(25);
        check("prio_req_count", req_log.size() - start, 2);
        if (req_log.size() >= start + 2) begin
            check("prio_first", req_log[start], 22'h00300);
            check("prio_second", req_log[start+1], 22'h00333);
        end

        // slot 0 moves address while its fetch is in flight
        ack_lat = 1;
        dat_lat = 3;
        fixed_data = 32'hCAFEF00D;
        start = req_log.size();
        addr_n[0] = 22'h00010;
        cs_n = 4'b0001;
        wait_phase(2);
        addr_n[0] = 22'h00020;
        steps(20);
        #1;
        check("move_req_count", req_log.size() - start, 2);
        if (req_log.size() >= start + 2) begin
            check("move_first", req_log[start], 22'h00010);
            check("move_second", req_log[start+1], 22'h00020);
        end
        check("move_slot_ok", slot_ok[0], 1);

        // downloading pulse while waiting for ack
        ack_lat = 3;
        dat_lat = 1;
        fixed_data = 32'h77777777;
        addr_n[1] = 22'h00077;
        cs_n = 4'b0110;
        wait_phase(1);
        dl_n = 1'b1;
        step();
        dl_n = 1'b0;
        start = req_log.size();
        step();
        #1;
        check("dl_sdram_req", sdram_req, 0);
        check("dl_slot_ok", slot_ok, 0);
        steps(20);
        check("dl_reissue", req_log.size() > start, 1);
        if (req_log.size() > start) check("dl_reissue_addr", req_log[start], 22'h00077);

        // reset while waiting for data, then a stray data_rdy
        ack_lat = 1;
        dat_lat = 4;
        addr_n[3] = 22'h00099;
        cs_n = 4'b1000;
        wait_phase(2);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        cs_n = 4'b0000;
        spur_rdy = 1'b1;
        step();
        spur_rdy = 1'b0;
        step();
        #1;
        check("rst_mid_sdram_addr", sdram_addr, 0);
        check("rst_mid_refresh_en", refresh_en, 1);
        cs_n = 4'b1000;
        step();
        #1;
        check("rst_mid_no_valid", slot_ok[3], 0);
        steps(15);

        // randomized soak
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < SLOTS; n++) begin
                if ($urandom_range(0, 5) == 0) cs_n[n] = ~cs_n[n];
                if ($urandom_range(0, 4) == 0) addr_n[n] = AW'($urandom_range(0, 5));
            end
            dl_n  = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 299) == 0);
            step();
        end
        rand_mode = 1'b0;
        dl_n = 1'b0;
        rst_n = 1'b0;
        cs_n = '0;
        ack_lat = 1;
        dat_lat = 1;
        steps(20);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/jtframe_rom_sched.md
JTFRAME_ROM_SCHED -- requirements
Module: jtframe_rom_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 4, meaning the number of ROM requesters, with slot 0 at highest priority.
REQ-002 SHALL have parameter AW, default 22, meaning the SDRAM word address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port slot_cs, input, SLOTS bits: per-slot read request, level.
REQ-006 SHALL have port slot_addr, input, SLOTS*AW bits: packed per-slot word address, with slot n at bits [n*AW +: AW].
REQ-007 SHALL have port slot_ok, output, SLOTS bits: slot data valid for the slot's current address.
REQ-008 SHALL have port slot_dout, output, SLOTS*32 bits: packed per-slot cached data.
REQ-009 SHALL have port downloading, input, 1 bit: ROM load in progress.
REQ-010 SHALL have port sdram_req, output, 1 bit: request to the SDRAM controller.
REQ-011 SHALL have port sdram_addr, output, AW bits: request address.
REQ-012 SHALL have port sdram_ack, input, 1 bit: controller accepted the request.
REQ-013 SHALL have port data_rdy, input, 1 bit: data_read is valid this cycle.
REQ-014 SHALL have port data_read, input, 32 bits: SDRAM read data.
REQ-015 SHALL have port refresh_en, output, 1 bit: controller may refresh now.

Function
REQ-016 SHALL keep one cache entry per slot: tag[AW], data[32], valid.
REQ-017 SHALL drive slot_ok[n] = slot_cs[n] & valid[n] & (tag[n]==slot_addr[n]), combinationally from the registered entry; slot_dout[n] = data[n].
REQ-018 SHALL mark a slot pending when slot_cs[n] is high and the slot misses (no valid entry with a matching tag).
REQ-019 SHALL use three FSM states: IDLE, WAIT_ACK and WAIT_DATA.
REQ-020 IDLE SHALL select the lowest-index pending slot, latch its index and address, set sdram_req=1 and go to WAIT_ACK; it SHALL stay in IDLE when no slot is pending.
REQ-021 WAIT_ACK SHALL hold sdram_req and sdram_addr stable until sdram_ack; on sdram_ack it SHALL clear sdram_req and go to WAIT_DATA.
REQ-022 WAIT_DATA SHALL, on data_rdy, write data_read and the latched address into the served slot's entry, set valid, and return to IDLE.
REQ-023 The path from data_rdy to slot_ok SHALL take 1 cycle, provided the slot still presents the same address.
REQ-024 If a slot changes address mid-transaction, the fetched word SHALL still be stored under the latched tag; slot_ok stays low and the slot re-arbitrates in IDLE.
REQ-025 If data_rdy and a new miss occur in the same cycle, the fill SHALL complete first and the miss SHALL be arbitrated in the following IDLE cycle.
REQ-026 The scheduler SHALL never have more than one outstanding SDRAM transaction.
REQ-027 SHALL drive refresh_en = 1 only in IDLE with no slot pending.
REQ-028 While downloading=1: FSM forced to IDLE, sdram_req=0, all valid bits cleared, refresh_en=0, slot_ok=0.
REQ-029 SHALL ignore sdram_ack outside WAIT_ACK and data_rdy outside WAIT_DATA.

Reset
REQ-030 On rst: FSM=IDLE, sdram_req=0, sdram_addr=0, all valid=0, tags=0, data=0.
REQ-031 Reset SHALL therefore leave slot_ok=0 and refresh_en=1 (provided no slot_cs is asserted).
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction without writing any cache entry; a late data_rdy after reset SHALL be ignored.

Structure
REQ-033 The FSM state encoding and the default SLOTS/AW SHALL live in shared package jtframe_rom_pkg.
REQ-034 The per-slot tag/data/valid entry plus its hit compare SHALL be sub-module jtframe_rom_slot, instantiated SLOTS times.
REQ-035 The top level SHALL contain only the priority select, FSM and SDRAM-side registers.

Verification
REQ-036 Single miss: slot1 cs, addr=0x00123, ack 2 cycles later, data_rdy 3 cycles after that with 0xDEADBEEF -> one sdram_req with addr 0x00123; slot_ok[1]=1 and dout=0xDEADBEEF 1 cycle after data_rdy.
REQ-037 Priority: slots 0 and 3 miss in the same cycle -> slot 0 is served first, slot 3 second, with no overlap of requests.
REQ-038 Hit: slot 2 re-requests its cached address -> slot_ok held high, no sdram_req.
REQ-039 Address change: slot 0 moves from 0x10 to 0x20 in WAIT_DATA -> the 0x10 fill is stored, slot_ok stays 0, and a new request with addr 0x20 follows.
REQ-040 Downloading pulse in WAIT_ACK -> sdram_req drops next cycle, all slot_ok=0, and a fresh request is issued after downloading falls.
REQ-041 rst in WAIT_DATA, then data_rdy -> no entry becomes valid, and refresh_en=1 while all slot_cs=0.
